// File: rtl/actuator_power_scheduler.sv
// Actuator power scheduler: drives home-actuator relays from level requests.
// It caps how many relays may be energised at once, spaces switch-on events
// so their inrush currents do not overlap, and holds each relay on for a
// minimum time so that a chattering request cannot toggle it rapidly.
module actuator_power_scheduler #(
  parameter int N_ACT      = 4,
  parameter int MAX_ON     = 2,
  parameter int GAP_CYC    = 16,
  parameter int MIN_ON_CYC = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [N_ACT-1:0]           req,
  output logic [N_ACT-1:0]           relay_on,
  output logic                       grant_pls,
  output logic [$clog2(N_ACT)-1:0]   grant_idx,
  output logic [N_ACT-1:0]           denied,
  output logic [$clog2(N_ACT+1)-1:0] on_count,
  output logic                       holdoff
);

  localparam int IDX_W = $clog2(N_ACT);
  localparam int CNT_W = $clog2(N_ACT + 1);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int TMR_W = $clog2(MIN_ON_CYC + 1);

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_t;

  state_t                        state_q, state_d;
  logic [GAP_W-1:0]              gap_cnt_q, gap_cnt_d;
  logic [N_ACT-1:0]              relay_on_q, relay_on_d;
  logic                          grant_pls_q, grant_pls_d;
  logic [IDX_W-1:0]              grant_idx_q, grant_idx_d;
  logic [N_ACT-1:0]              denied_q, denied_d;
  logic [CNT_W-1:0]              on_count_q, on_count_d;
  logic                          holdoff_q, holdoff_d;
  logic [N_ACT-1:0][TMR_W-1:0]   timer_q, timer_d;

  logic [N_ACT-1:0]              release_vec;
  logic [N_ACT-1:0]              grant_vec;
  logic                          grant_found;
  logic [IDX_W-1:0]              grant_sel;

  // A relay may drop once its request is gone and its minimum on-time has elapsed.
  always_comb begin
    release_vec = '0;
    for (int i = 0; i < N_ACT; i++) begin
      release_vec[i] = relay_on_q[i] & ~req[i] & (timer_q[i] >= TMR_W'(MIN_ON_CYC));
    end
  end

  // Pick the lowest-index pending request when idle and below the cap (pre-release count).
  always_comb begin
    grant_vec   = '0;
    grant_found = 1'b0;
    grant_sel   = '0;
    if (enable && (state_q == IDLE) && (on_count_q < CNT_W'(MAX_ON))) begin
      for (int i = 0; i < N_ACT; i++) begin
        if (!grant_found && req[i] && !relay_on_q[i]) begin
          grant_vec[i] = 1'b1;
          grant_found  = 1'b1;
          grant_sel    = IDX_W'(i);
        end
      end
    end
  end

  // Next-state logic for the FSM, relay vector and the registered status outputs.
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    grant_pls_d = 1'b0;
    grant_idx_d = grant_idx_q;
    relay_on_d  = (relay_on_q & ~release_vec) | grant_vec;

    if (!enable) begin
      relay_on_d = '0;
      state_d    = IDLE;
      gap_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            state_d     = GAP;
            gap_cnt_d   = GAP_W'(GAP_CYC - 1);
            grant_pls_d = 1'b1;
            grant_idx_d = grant_sel;
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end
        default: begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end
      endcase
    end

    holdoff_d  = (state_d == GAP);
    denied_d   = req & ~relay_on_d;
    on_count_d = '0;
    for (int i = 0; i < N_ACT; i++) begin
      on_count_d = on_count_d + CNT_W'(relay_on_d[i]);
    end
  end

  // On-timers restart at grant, count while the relay is on and saturate at the minimum.
  always_comb begin
    timer_d = timer_q;
    for (int i = 0; i < N_ACT; i++) begin
      if (!relay_on_d[i] || grant_vec[i]) begin
        timer_d[i] = '0;
      end else if (timer_q[i] < TMR_W'(MIN_ON_CYC)) begin
        timer_d[i] = timer_q[i] + TMR_W'(1);
      end
    end
  end

  // All state and outputs are registered; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gap_cnt_q   <= '0;
      relay_on_q  <= '0;
      grant_pls_q <= 1'b0;
      grant_idx_q <= '0;
      denied_q    <= '0;
      on_count_q  <= '0;
      holdoff_q   <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      relay_on_q  <= relay_on_d;
      grant_pls_q <= grant_pls_d;
      grant_idx_q <= grant_idx_d;
      denied_q    <= denied_d;
      on_count_q  <= on_count_d;
      holdoff_q   <= holdoff_d;
      timer_q     <= timer_d;
    end
  end

  assign relay_on  = relay_on_q;
  assign grant_pls = grant_pls_q;
  assign grant_idx = grant_idx_q;
  assign denied    = denied_q;
  assign on_count  = on_count_q;
  assign holdoff   = holdoff_q;

endmodule

// File: tb/tb_actuator_power_scheduler.sv
// Directed testbench for actuator_power_scheduler with default parameters
// (4 channels, at most 2 on, 16-cycle inrush gap, 32-cycle minimum on-time).
module tb_actuator_power_scheduler;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] req;
  logic [3:0] relay_on;
  logic       grant_pls;
  logic [1:0] grant_idx;
  logic [3:0] denied;
  logic [2:0] on_count;
  logic       holdoff;

  int checks = 0;
  int errors = 0;
  int cycle_count = 0;
  int last_grant = -1000;

  actuator_power_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req       (req),
    .relay_on  (relay_on),
    .grant_pls (grant_pls),
    .grant_idx (grant_idx),
    .denied    (denied),
    .on_count  (on_count),
    .holdoff   (holdoff)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] r);
    enable = en;
    req    = r;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drop everything for one cycle so the next scenario starts from IDLE.
  task automatic clearAll();
    applyStimulus(1'b0, 4'b0000);
    waitCycles(1);
    checkOutput("clear_relay_on", relay_on, 4'b0000);
  endtask

  // Invariants checked after every active edge: cap, popcount, denied and grant spacing.
  initial begin
    logic en_at_edge;
    logic rst_at_edge;
    forever begin
      @(posedge clk);
      cycle_count++;
      en_at_edge  = enable;
      rst_at_edge = rst_n;
      #2;
      if (!rst_n || !rst_at_edge || !en_at_edge) begin
        last_grant = -1000;
      end else begin
        checkOutput("cap_on_count", {31'd0, on_count <= 3'd2}, 32'd1);
        checkOutput("popcount", on_count, $countones(relay_on));
        checkOutput("denied_coherent", denied, req & ~relay_on);
        if (grant_pls) begin
          checkOutput("grant_spacing", {31'd0, (cycle_count - last_grant) >= 16}, 32'd1);
          last_grant = cycle_count;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 4'b0000);
    #3;
    checkOutput("reset_relay_on", relay_on, 4'b0000);
    checkOutput("reset_grant_pls", grant_pls, 1'b0);
    checkOutput("reset_grant_idx", grant_idx, 2'd0);
    checkOutput("reset_denied", denied, 4'b0000);
    checkOutput("reset_on_count", on_count, 3'd0);
    checkOutput("reset_holdoff", holdoff, 1'b0);
    waitCycles(2);
    rst_n = 1'b1;

    // Single grant
    applyStimulus(1'b1, 4'b0010);
    waitCycles(1);
    checkOutput("s1_relay_on", relay_on, 4'b0010);
    checkOutput("s1_grant_pls", grant_pls, 1'b1);
    checkOutput("s1_grant_idx", grant_idx, 2'd1);
    checkOutput("s1_holdoff_start", holdoff, 1'b1);
    checkOutput("s1_on_count", on_count, 3'd1);
    waitCycles(1);
    checkOutput("s1_pulse_one_cycle", grant_pls, 1'b0);
    waitCycles(14);
    checkOutput("s1_holdoff_c16", holdoff, 1'b1);
    waitCycles(1);
    checkOutput("s1_holdoff_c17", holdoff, 1'b0);
    clearAll();

    // Inrush spacing
    applyStimulus(1'b1, 4'b0011);
    waitCycles(1);
    checkOutput("s2_relay_on_c1", relay_on, 4'b0001);
    checkOutput("s2_grant_idx_c1", grant_idx, 2'd0);
    checkOutput("s2_denied_c1", denied, 4'b0010);
    waitCycles(16);
    checkOutput("s2_relay_on_c17", relay_on, 4'b0001);
    checkOutput("s2_grant_idx_hold", grant_idx, 2'd0);
    waitCycles(1);
    checkOutput("s2_relay_on_c18", relay_on, 4'b0011);
    checkOutput("s2_grant_pls_c18", grant_pls, 1'b1);
    checkOutput("s2_grant_idx_c18", grant_idx, 2'd1);
    clearAll();

    // Cap at two relays, then a freed slot goes to the next channel
    applyStimulus(1'b1, 4'b1111);
    waitCycles(18);
    checkOutput("s3_relay_on_c18", relay_on, 4'b0011);
    checkOutput("s3_denied_c18", denied, 4'b1100);
    checkOutput("s3_on_count_c18", on_count, 3'd2);
    waitCycles(22);
    checkOutput("s3_relay_on_c40", relay_on, 4'b0011);
    applyStimulus(1'b1, 4'b1110);
    waitCycles(1);
    checkOutput("s3_release_c41", relay_on, 4'b0010);
    checkOutput("s3_no_grant_c41", grant_pls, 1'b0);
    checkOutput("s3_on_count_c41", on_count, 3'd1);
    waitCycles(1);
    checkOutput("s3_relay_on_c42", relay_on, 4'b0110);
    checkOutput("s3_grant_idx_c42", grant_idx, 2'd2);
    checkOutput("s3_denied_c42", denied, 4'b1000);
    clearAll();

    // Minimum on-time
    applyStimulus(1'b1, 4'b1000);
    waitCycles(1);
    checkOutput("s4_relay_on_c1", relay_on, 4'b1000);
    checkOutput("s4_grant_idx_c1", grant_idx, 2'd3);
    waitCycles(4);
    applyStimulus(1'b1, 4'b0000);
    waitCycles(28);
    checkOutput("s4_still_on_c33", relay_on, 4'b1000);
    waitCycles(1);
    checkOutput("s4_released_c34", relay_on, 4'b0000);
    clearAll();

    // Enable abort while two relays are on and the gap is running
    applyStimulus(1'b1, 4'b0111);
    waitCycles(18);
    checkOutput("s5_relay_on_c18", relay_on, 4'b0011);
    checkOutput("s5_holdoff_c18", holdoff, 1'b1);
    applyStimulus(1'b0, 4'b0111);
    waitCycles(1);
    checkOutput("s5_abort_relay_on", relay_on, 4'b0000);
    checkOutput("s5_abort_holdoff", holdoff, 1'b0);
    checkOutput("s5_abort_on_count", on_count, 3'd0);
    checkOutput("s5_abort_denied", denied, 4'b0111);
    applyStimulus(1'b1, 4'b0001);
    waitCycles(1);
    checkOutput("s5_regrant_relay_on", relay_on, 4'b0001);
    checkOutput("s5_regrant_pls", grant_pls, 1'b1);
    clearAll();

    // Asynchronous reset in the middle of a gap
    applyStimulus(1'b1, 4'b0010);
    waitCycles(3);
    checkOutput("s6_pre_reset_holdoff", holdoff, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("s6_async_relay_on", relay_on, 4'b0000);
    checkOutput("s6_async_holdoff", holdoff, 1'b0);
    checkOutput("s6_async_on_count", on_count, 3'd0);
    checkOutput("s6_async_grant_idx", grant_idx, 2'd0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(1);
    checkOutput("s6_after_relay_on", relay_on, 4'b0010);
    checkOutput("s6_after_grant_pls", grant_pls, 1'b1);
    checkOutput("s6_after_grant_idx", grant_idx, 2'd1);
    checkOutput("s6_after_holdoff", holdoff, 1'b1);
    waitCycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
